ctrl_sequencer: RTL

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/eater_pkg.sv | 43 ++++
 rtl/ctrl_microcode.sv | 54 +++++
 rtl/ctrl_sequencer.sv | 69 ++++++
 3 files changed

// File: rtl/eater_pkg.sv
// Shared definitions for the microcoded CPU control path: control-word bit
// positions, opcodes and default microstep counts.
package eater_pkg;

  localparam int NUM_STEPS_DEF   = 5;
  localparam int FETCH_STEPS_DEF = 2;

  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [15:0] cw_bit(input int idx);
    return 16'(1) << idx;
  endfunction

  localparam logic [15:0] CW_HLT = cw_bit(B_HLT);

endpackage

// File: rtl/ctrl_microcode.sv
// Combinational microcode ROM: (opcode, microstep, flags) -> control word.
module ctrl_microcode
  import eater_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [2:0]  step,
  input  logic        ovf,
  input  logic        zf,
  output logic [15:0] word
);

  localparam logic [15:0] CW_FETCH0 = cw_bit(B_MI) | cw_bit(B_CO);
  localparam logic [15:0] CW_FETCH1 = cw_bit(B_RO) | cw_bit(B_II) | cw_bit(B_CE);
  localparam logic [15:0] CW_MADDR  = cw_bit(B_IO) | cw_bit(B_MI);
  localparam logic [15:0] CW_JUMP   = cw_bit(B_IO) | cw_bit(B_J);
  localparam logic [15:0] CW_ALU    = cw_bit(B_EO) | cw_bit(B_AI) | cw_bit(B_FI);

  always_comb begin
    word = '0;
    case (step)
      3'd0: word = CW_FETCH0;
      3'd1: word = CW_FETCH1;
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: word = CW_MADDR;
          OP_LDI: word = cw_bit(B_IO) | cw_bit(B_AI);
          OP_JMP: word = CW_JUMP;
          OP_JC:  word = ovf ? CW_JUMP : 16'h0000;
          OP_JZ:  word = zf  ? CW_JUMP : 16'h0000;
          OP_OUT: word = cw_bit(B_AO) | cw_bit(B_OI);
          OP_HLT: word = CW_HLT;
          default: ;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA:         word = cw_bit(B_RO) | cw_bit(B_AI);
          OP_ADD, OP_SUB: word = cw_bit(B_RO) | cw_bit(B_BI);
          OP_STA:         word = cw_bit(B_AO) | cw_bit(B_RI);
          default: ;
        endcase
      end
      3'd4: begin
        case (opcode)
          OP_ADD: word = CW_ALU;
          OP_SUB: word = CW_ALU | cw_bit(B_SU);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Microstep counter with halt latch; the control word comes from ctrl_microcode
// and is forced to HLT once the sequencer has halted.
module ctrl_sequencer
  import eater_pkg::*;
#(
  parameter int NUM_STEPS   = NUM_STEPS_DEF,
  parameter int FETCH_STEPS = FETCH_STEPS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [7:0]  instruction_data,
  input  logic        ovf,
  input  logic        zf,
  output logic [15:0] ctrl_state,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [2:0] LAST_STEP  = 3'(NUM_STEPS - 1);
  localparam logic [2:0] FETCH_STEP = 3'(FETCH_STEPS);

  logic [2:0]  step_q, step_d;
  logic        halted_q, halted_d;
  logic [15:0] mc_word;
  logic        unused_operand;

  assign unused_operand = ^instruction_data[3:0];

  ctrl_microcode u_microcode (
    .opcode (instruction_data[7:4]),
    .step   (step_q),
    .ovf    (ovf),
    .zf     (zf),
    .word   (mc_word)
  );

  assign ctrl_state = halted_q ? CW_HLT : mc_word;
  assign step       = step_q;
  assign halted     = halted_q;

  // An all-zero execute step ends the instruction early; fetch steps always run.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (run && !halted_q) begin
      if (ctrl_state[B_HLT]) begin
        halted_d = 1'b1;
      end else if (step_q == LAST_STEP) begin
        step_d = '0;
      end else if (step_q >= FETCH_STEP && ctrl_state == 16'h0000) begin
        step_d = '0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

endmodule
